// File: rtl/pipe_mem_arb_if.sv
// Bundle of fetch, data and memory-bus signals for pipe_mem_arb.
// slave = arbiter side, master = client/memory environment side.
interface pipe_mem_arb_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [47:0] if_inst;
    logic        if_ack;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, bus_rdata, bus_ack,
        output if_inst, if_ack, dm_rdata, dm_ack, bus_req, bus_we, bus_addr, bus_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, bus_rdata, bus_ack,
        input  if_inst, if_ack, dm_rdata, dm_ack, bus_req, bus_we, bus_addr, bus_wdata
    );
endinterface

// File: rtl/pipe_mem_arb.sv
// Arbitrates instruction fetch (two 32-bit beats -> 48-bit instruction) and data access onto one memory bus.
// Define ARB_STARVE_GUARD_EN to force a fetch after STARVE_LIMIT consecutive contended data grants.
module pipe_mem_arb #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    pipe_mem_arb_if.slave arbIf
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] FETCH0 = 2'd2;
    localparam logic [1:0] FETCH1 = 2'd3;

    if (STARVE_LIMIT < 1) begin : gLimitCheck
        $error("pipe_mem_arb: STARVE_LIMIT must be at least 1");
    end

    logic [1:0]  stateReg;
    logic [1:0]  stateNext;
    logic        ifAckReg;
    logic        dmAckReg;
    logic [47:0] ifInstReg;
    logic [31:0] dmRdataReg;
    logic        arbGo;
    logic        grantFetch;

    // The ack cycle is a turnaround: neither port is arbitrated, so a finishing master
    // can re-present its request on equal footing with the waiting one.
    assign arbGo = (stateReg == IDLE) && !ifAckReg && !dmAckReg;

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    logic [CntW-1:0] starveCnt;

    assign grantFetch = arbIf.if_req && (!arbIf.dm_req || (starveCnt >= CntW'(STARVE_LIMIT)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starveCnt <= '0;
        end else if (arbGo && grantFetch) begin
            starveCnt <= '0;
        end else if (arbGo && arbIf.dm_req) begin
            starveCnt <= arbIf.if_req ? starveCnt + CntW'(1) : '0;
        end
    end
`else
    assign grantFetch = arbIf.if_req && !arbIf.dm_req;
`endif

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (arbGo) begin
                    if (grantFetch) begin
                        stateNext = FETCH0;
                    end else if (arbIf.dm_req) begin
                        stateNext = DATA;
                    end
                end
            end
            DATA:    if (arbIf.bus_ack) stateNext = IDLE;
            FETCH0:  if (arbIf.bus_ack) stateNext = FETCH1;
            FETCH1:  if (arbIf.bus_ack) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Bus side is decoded from state so reset drops bus_req without waiting for a clock.
    always_comb begin
        arbIf.bus_req   = 1'b0;
        arbIf.bus_we    = 1'b0;
        arbIf.bus_addr  = 32'h0;
        arbIf.bus_wdata = 32'h0;
        case (stateReg)
            DATA: begin
                arbIf.bus_req   = 1'b1;
                arbIf.bus_we    = arbIf.dm_we;
                arbIf.bus_addr  = arbIf.dm_addr;
                arbIf.bus_wdata = arbIf.dm_we ? arbIf.dm_wdata : 32'h0;
            end
            FETCH0: begin
                arbIf.bus_req  = 1'b1;
                arbIf.bus_addr = arbIf.if_addr;
            end
            FETCH1: begin
                arbIf.bus_req  = 1'b1;
                arbIf.bus_addr = arbIf.if_addr + 32'd4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg   <= IDLE;
            ifAckReg   <= 1'b0;
            dmAckReg   <= 1'b0;
            ifInstReg  <= 48'h0;
            dmRdataReg <= 32'h0;
        end else begin
            stateReg <= stateNext;
            dmAckReg <= (stateReg == DATA) && arbIf.bus_ack;
            ifAckReg <= (stateReg == FETCH1) && arbIf.bus_ack;
            if ((stateReg == DATA) && arbIf.bus_ack && !arbIf.dm_we) begin
                dmRdataReg <= arbIf.bus_rdata;
            end
            if ((stateReg == FETCH0) && arbIf.bus_ack) begin
                ifInstReg[47:16] <= arbIf.bus_rdata;
            end
            if ((stateReg == FETCH1) && arbIf.bus_ack) begin
                ifInstReg[15:0] <= arbIf.bus_rdata[31:16];
            end
        end
    end

    assign arbIf.if_ack   = ifAckReg;
    assign arbIf.dm_ack   = dmAckReg;
    assign arbIf.if_inst  = ifInstReg;
    assign arbIf.dm_rdata = dmRdataReg;
endmodule

// File: tb/tb_pipe_mem_arb.sv
// Scoreboard bench for pipe_mem_arb: client tasks push expected results, a negedge monitor pops and compares.
module tb_pipe_mem_arb;
    logic clk;
    logic rst;

    pipe_mem_arb_if arbIf ();

    pipe_mem_arb #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .arbIf (arbIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int assertCnt = 0;
    int failCnt   = 0;

    logic [31:0] expDm[$];
    logic [47:0] expIf[$];
    logic [64:0] expBus[$];
    bit          busChk = 1'b1;
    logic [31:0] lastDm = 32'h0;
    logic [63:0] ackBits = 64'h0;
    int          ackCnt = 0;
    int          lastBusLen = 0;

    // memory model
    int          memLat = 0;
    int          waitCnt = 0;
    bit          stallEn = 1'b0;
    logic [31:0] stallAddr = 32'h0;

    function automatic logic [31:0] memPat(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'hDEAD_BEEF;
            32'h0000_0020: return 32'h30F4_0A00;
            32'h0000_0024: return 32'h0000_FFFF;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
        endcase
    endfunction

    function automatic logic [47:0] instPat(input logic [31:0] a);
        logic [31:0] hi;
        logic [31:0] lo;
        hi = memPat(a);
        lo = memPat(a + 32'd4);
        return {hi, lo[31:16]};
    endfunction

    assign arbIf.bus_rdata = arbIf.bus_req ? memPat(arbIf.bus_addr) : 32'h0;
    assign arbIf.bus_ack   = arbIf.bus_req && (waitCnt >= memLat) &&
                             !(stallEn && (arbIf.bus_addr == stallAddr));

    always @(posedge clk) begin
        if (!arbIf.bus_req || arbIf.bus_ack) waitCnt <= 0;
        else                                 waitCnt <= waitCnt + 1;
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assertCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // negedge monitor / scoreboard
    initial begin
        logic        prevReq;
        logic        prevAck;
        logic [31:0] prevAddr;
        logic        prevWe;
        logic [31:0] prevWdata;
        logic [64:0] e;
        int          busLen;
        prevReq = 1'b0; prevAck = 1'b0; prevAddr = '0; prevWe = 1'b0; prevWdata = '0; busLen = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevReq = 1'b0;
                prevAck = 1'b0;
                busLen  = 0;
            end else begin
                if (arbIf.bus_req && prevReq && !prevAck) begin
                    checkVal("bus_addr_stable", arbIf.bus_addr, prevAddr);
                    checkVal("bus_we_stable", arbIf.bus_we, prevWe);
                    checkVal("bus_wdata_stable", arbIf.bus_wdata, prevWdata);
                end
                if (arbIf.bus_req && !arbIf.bus_we) checkVal("bus_wdata_zero", arbIf.bus_wdata, 0);
                if (arbIf.bus_req) busLen++;
                if (arbIf.bus_req && arbIf.bus_ack) begin
                    lastBusLen = busLen;
                    busLen = 0;
                    if (busChk) begin
                        if (expBus.size() == 0) begin
                            checkVal("bus_unexpected", 1, 0);
                        end else begin
                            e = expBus.pop_front();
                            checkVal("bus_addr", arbIf.bus_addr, e[64:33]);
                            checkVal("bus_we", arbIf.bus_we, e[32]);
                            checkVal("bus_wdata", arbIf.bus_wdata, e[31:0]);
                        end
                    end
                end
                if (arbIf.dm_ack || arbIf.if_ack) checkVal("bus_idle_gap", arbIf.bus_req, 0);
                if (arbIf.dm_ack) begin
                    $display("dm ack rdata=%h", arbIf.dm_rdata);
                    ackBits = {ackBits[62:0], 1'b0};
                    ackCnt++;
                    if (expDm.size() == 0) checkVal("dm_ack_unexpected", 1, 0);
                    else                   checkVal("dm_rdata", arbIf.dm_rdata, expDm.pop_front());
                end
                if (arbIf.if_ack) begin
                    $display("if ack inst=%h", arbIf.if_inst);
                    ackBits = {ackBits[62:0], 1'b1};
                    ackCnt++;
                    if (expIf.size() == 0) checkVal("if_ack_unexpected", 1, 0);
                    else                   checkVal("if_inst", arbIf.if_inst, expIf.pop_front());
                end
                prevReq   = arbIf.bus_req;
                prevAck   = arbIf.bus_ack;
                prevAddr  = arbIf.bus_addr;
                prevWe    = arbIf.bus_we;
                prevWdata = arbIf.bus_wdata;
            end
        end
    end

    task automatic dmXfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit chkLat, input int expLat);
        int cyc;
        @(posedge clk); #1;
        arbIf.dm_req   = 1'b1;
        arbIf.dm_we    = we;
        arbIf.dm_addr  = addr;
        arbIf.dm_wdata = wdata;
        if (!we) lastDm = memPat(addr);
        expDm.push_back(lastDm);
        if (busChk) expBus.push_back({addr, we, we ? wdata : 32'h0});
        cyc = 0;
        while (!arbIf.dm_ack && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!arbIf.dm_ack) checkVal("dm_timeout", 0, 1);
        else if (chkLat)   checkVal("dm_latency", cyc, expLat);
    endtask

    task automatic dmIdle();
        @(posedge clk); #1;
        arbIf.dm_req = 1'b0;
    endtask

    task automatic ifXfer(input logic [31:0] addr, input bit chkLat, input int expLat);
        int cyc;
        @(posedge clk); #1;
        arbIf.if_req  = 1'b1;
        arbIf.if_addr = addr;
        expIf.push_back(instPat(addr));
        if (busChk) begin
            expBus.push_back({addr, 1'b0, 32'h0});
            expBus.push_back({addr + 32'd4, 1'b0, 32'h0});
        end
        cyc = 0;
        while (!arbIf.if_ack && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!arbIf.if_ack) checkVal("if_timeout", 0, 1);
        else if (chkLat)   checkVal("if_latency", cyc, expLat);
    endtask

    task automatic ifIdle();
        @(posedge clk); #1;
        arbIf.if_req = 1'b0;
    endtask

    initial begin
        int cyc;
        int kind;
        logic [31:0] a;
        rst = 1'b1;
        arbIf.if_req = 1'b0; arbIf.if_addr = '0;
        arbIf.dm_req = 1'b0; arbIf.dm_we = 1'b0; arbIf.dm_addr = '0; arbIf.dm_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst_bus_req", arbIf.bus_req, 0);
        checkVal("rst_bus_addr", arbIf.bus_addr, 0);
        checkVal("rst_acks", {arbIf.if_ack, arbIf.dm_ack}, 0);
        checkVal("rst_if_inst", arbIf.if_inst, 0);
        checkVal("rst_dm_rdata", arbIf.dm_rdata, 0);
        @(negedge clk);
        rst = 1'b0;

        // single read, zero-wait memory
        memLat = 0;
        dmXfer(1'b0, 32'h100, 32'h0, 1'b1, 2);
        dmIdle();
        // fetch assembly
        ifXfer(32'h20, 1'b1, 3);
        ifIdle();
        // address wrap on second beat
        ifXfer(32'hFFFF_FFFC, 1'b1, 3);
        ifIdle();
        // write with a slow memory: read data must stay put
        memLat = 5;
        dmXfer(1'b1, 32'h180, 32'hCAFE_F00D, 1'b1, 7);
        dmIdle();
        checkVal("write_bus_len", lastBusLen, 6);
        checkVal("write_rdata_hold", arbIf.dm_rdata, 32'hDEAD_BEEF);

        // mixed traffic with varied latency
        for (int i = 0; i < 8; i++) begin
            kind   = $urandom_range(0, 2);
            memLat = $urandom_range(0, 3);
            a      = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            if (kind == 2) begin
                ifXfer(a, 1'b1, 3 + 2 * memLat);
                ifIdle();
            end else begin
                dmXfer(kind == 1, a, $urandom, 1'b1, 2 + memLat);
                dmIdle();
            end
        end

        // contention: both clients hold requests back to back
        memLat = 0;
        busChk = 1'b0;
        ackBits = 64'h0;
        ackCnt = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) dmXfer(1'b0, 32'h200 + 32'(4 * i), 32'h0, 1'b0, 0);
                dmIdle();
            end
            begin
                for (int i = 0; i < 2; i++) ifXfer(32'h300 + 32'(8 * i), 1'b0, 0);
                ifIdle();
            end
        join
        checkVal("contend_ack_count", ackCnt, 8);
`ifdef ARB_STARVE_GUARD_EN
        checkVal("contend_order", ackBits, 64'h09);  // D D D D F D D F
`else
        checkVal("contend_order", ackBits, 64'h03);  // D D D D D D F F
`endif
        busChk = 1'b1;

        // reset while the second fetch beat is waiting on memory
        stallEn   = 1'b1;
        stallAddr = 32'h44;
        @(posedge clk); #1;
        arbIf.if_req  = 1'b1;
        arbIf.if_addr = 32'h40;
        expBus.push_back({32'h40, 1'b0, 32'h0});
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(arbIf.bus_req && arbIf.bus_addr == 32'h44) && cyc < 50);
        checkVal("fetch1_reached", arbIf.bus_addr, 32'h44);
        #2;
        rst = 1'b1;
        #1;
        checkVal("rst_f1_bus_req", arbIf.bus_req, 0);
        checkVal("rst_f1_if_inst", arbIf.if_inst, 0);
        checkVal("rst_f1_if_ack", arbIf.if_ack, 0);
        checkVal("rst_f1_dm_rdata", arbIf.dm_rdata, 0);
        lastDm  = 32'h0;
        stallEn = 1'b0;
        expBus.push_back({32'h40, 1'b0, 32'h0});
        expBus.push_back({32'h44, 1'b0, 32'h0});
        expIf.push_back(instPat(32'h40));
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b0;
        cyc = 0;
        while (!arbIf.if_ack && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkVal("rst_restart_latency", cyc, 3);
        ifIdle();
        dmXfer(1'b0, 32'h100, 32'h0, 1'b1, 2);
        dmIdle();

        repeat (4) @(posedge clk);
        checkVal("dm_queue_drained", expDm.size(), 0);
        checkVal("if_queue_drained", expIf.size(), 0);
        checkVal("bus_queue_drained", expBus.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end
endmodule
